// File: rtl/tick_period_monitor.sv
// Tick period checker: edge-detects the 1 Hz strobe, measures edge-to-edge period, grades it, tracks lock/missing.
// Latency: all outputs registered, strobes appear 1 cycle after the deciding clk edge.
// Backpressure: none; free-running monitor, every tick edge is evaluated in the cycle it occurs.
module tick_period_monitor #(
    parameter int NOMINAL = 1000,
    parameter int TOL     = 2,
    parameter int LOCK_N  = 3,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             early,
    output logic             late,
    output logic             missing,
    output logic             lock
);

    localparam int STREAK_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]    GOOD_LO  = CNT_W'(NOMINAL - TOL);
    localparam logic [CNT_W-1:0]    GOOD_HI  = CNT_W'(NOMINAL + TOL);
    localparam logic [CNT_W-1:0]    TIMEOUT  = CNT_W'(NOMINAL + TOL + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LOCK_N);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t              state;
    logic                tick_prev;
    logic [CNT_W-1:0]    elapsed;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_inc;
    logic                edge_det;

    assign edge_det   = tick_in & ~tick_prev;
    assign streak_inc = (streak == STREAK_MAX) ? streak : streak + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tick_prev    <= 1'b0;
            elapsed      <= '0;
            streak       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            early        <= 1'b0;
            late         <= 1'b0;
            missing      <= 1'b0;
            lock         <= 1'b0;
        end else begin
            // tick_prev follows tick_in even while disabled, so a tick held
            // across re-enable is not mistaken for a fresh edge.
            tick_prev    <= tick_in;
            period_valid <= 1'b0;
            early        <= 1'b0;
            late         <= 1'b0;

            if (!enable) begin
                state   <= IDLE;
                elapsed <= '0;
                streak  <= '0;
                lock    <= 1'b0;
                missing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (edge_det) begin
                            state   <= MEASURE;
                            elapsed <= CNT_W'(1);
                        end else begin
                            elapsed <= '0;
                        end
                    end
                    MEASURE: begin
                        if (edge_det) begin
                            // elapsed equals cycles since previous edge here
                            period       <= elapsed;
                            period_valid <= 1'b1;
                            elapsed      <= CNT_W'(1);
                            if (elapsed < GOOD_LO) begin
                                early  <= 1'b1;
                                streak <= '0;
                                lock   <= 1'b0;
                            end else if (elapsed <= GOOD_HI) begin
                                streak  <= streak_inc;
                                lock    <= (streak_inc == STREAK_MAX);
                                missing <= 1'b0;
                            end else begin
                                late   <= 1'b1;
                                streak <= '0;
                                lock   <= 1'b0;
                            end
                        end else if (elapsed == TIMEOUT) begin
                            // Timebase lost: drop back and wait for a fresh reference edge.
                            late    <= 1'b1;
                            missing <= 1'b1;
                            lock    <= 1'b0;
                            streak  <= '0;
                            elapsed <= '0;
                            state   <= IDLE;
                        end else begin
                            elapsed <= elapsed + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        elapsed <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor: table of tick gaps with hand-computed results plus reset/enable sequences.
module tb_tick_period_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tick_in;
    logic [10:0] period;
    logic        period_valid;
    logic        early;
    logic        late;
    logic        missing;
    logic        lock;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_hold = 1;
    bit spur;

    always #5 clk = ~clk;

    tick_period_monitor #(
        .NOMINAL(1000),
        .TOL    (2),
        .LOCK_N (3),
        .CNT_W  (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick_in     (tick_in),
        .period      (period),
        .period_valid(period_valid),
        .early       (early),
        .late        (late),
        .missing     (missing),
        .lock        (lock)
    );

    typedef struct {
        int gap;   // cycles from previous edge to end of this record
        bit tk;    // an edge occurs at the end of the gap
        int hold;  // width of the pulse emitted at the end
        bit pv;
        int per;
        bit er;
        bit lt;
        bit ms;
        bit lk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int gap, bit tk, int hold, bit pv, int per,
                                bit er, bit lt, bit ms, bit lk);
        vec_t v;
        v.gap = gap; v.tk = tk; v.hold = hold; v.pv = pv; v.per = per;
        v.er = er; v.lt = lt; v.ms = ms; v.lk = lk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance gap cycles; inputs are driven and outputs sampled on negedges.
    task automatic do_gap(input int gap, input bit tk, input int hold);
        spur = 1'b0;
        for (int i = 1; i <= gap; i++) begin
            tick_in = (i < cur_hold) || (tk && i == gap);
            @(negedge clk);
            if (i < gap && (period_valid || early || late)) spur = 1'b1;
        end
        cur_hold = tk ? hold : 1;
    endtask

    task automatic chk_all(input string tag, input bit pv, input int per,
                           input bit er, input bit lt, input bit ms, input bit lk);
        chk({tag, ".period_valid"}, period_valid, pv);
        chk({tag, ".period"}, period, per);
        chk({tag, ".early"}, early, er);
        chk({tag, ".late"}, late, lt);
        chk({tag, ".missing"}, missing, ms);
        chk({tag, ".lock"}, lock, lk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; tick_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0; enable = 1'b1;

        // Steady 1000-cycle ticks and lock acquisition
        vecs.push_back(mk(5,    1, 1, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 1));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 1));
        // Early period breaks lock, three good re-lock
        vecs.push_back(mk(900,  1, 1, 1, 900,  1, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 1));
        // Window edges, then late-by-one with edge (stays measuring)
        vecs.push_back(mk(998,  1, 1, 1, 998,  0, 0, 0, 1));
        vecs.push_back(mk(1002, 1, 1, 1, 1002, 0, 0, 0, 1));
        vecs.push_back(mk(1003, 1, 1, 1, 1003, 0, 1, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 1));
        // Missing tick: timeout, silent reference edge, then recovery
        vecs.push_back(mk(1003, 0, 1, 0, 1000, 0, 1, 1, 0));
        vecs.push_back(mk(50,   1, 1, 0, 1000, 0, 0, 1, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 1, 1, 1000, 0, 0, 0, 1));
        // Wide 5-cycle pulses count once per period
        vecs.push_back(mk(900,  1, 5, 1, 900,  1, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 5, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 5, 1, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1000, 1, 5, 1, 1000, 0, 0, 0, 1));

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            do_gap(vecs[k].gap, vecs[k].tk, vecs[k].hold);
            chk({tag, ".no_strobe_in_gap"}, spur, 0);
            chk_all(tag, vecs[k].pv, vecs[k].per, vecs[k].er, vecs[k].lt,
                    vecs[k].ms, vecs[k].lk);
        end

        // Reset mid-period; tick high across reset release counts as an edge
        do_gap(300, 0, 1);
        rst = 1'b1; tick_in = 1'b1;
        @(negedge clk);
        chk_all("midrst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_edge.period_valid", period_valid, 0);
        cur_hold = 1;
        for (int k = 0; k < 3; k++) begin
            do_gap(1000, 1, 1);
            chk($sformatf("relock%0d.period_valid", k), period_valid, 1);
            chk($sformatf("relock%0d.period", k), period, 1000);
            chk($sformatf("relock%0d.lock", k), lock, (k == 2) ? 1 : 0);
        end

        // Disable for 200 cycles with a tick inside it
        spur = 1'b0;
        enable = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick_in = (i >= 100 && i < 103);
            @(negedge clk);
            if (period_valid || early || late) spur = 1'b1;
        end
        chk("dis.no_strobe", spur, 0);
        chk("dis.lock", lock, 0);
        chk("dis.missing", missing, 0);
        chk("dis.period_held", period, 1000);

        // After re-enable the first edge is only a reference; streak restarts
        enable = 1'b1; cur_hold = 1;
        do_gap(20, 1, 1);
        chk("reen_ref.period_valid", period_valid, 0);
        do_gap(1000, 1, 1);
        chk("reen1.period_valid", period_valid, 1);
        chk("reen1.period", period, 1000);
        chk("reen1.lock", lock, 0);

        // Disable clears missing
        do_gap(1003, 0, 1);
        chk("tmo2.late", late, 1);
        chk("tmo2.missing", missing, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis2.missing", missing, 0);
        chk("dis2.late", late, 0);
        enable = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
Receive-side checker for the 1 Hz tick strobe produced by the clock-divider stage. Detects each tick edge and measures the number of clk cycles between consecutive edges. Classifies each period as good, early or late, and flags a missing tick on timeout. Drives a lock indication consumed by the water-level control logic, so that timed actions (sampling, pump on-times) only run on a verified timebase.

Parameters:
NOMINAL, 1000, expected clk cycles between ticks
TOL, 2, allowed ± deviation in cycles; good window is [NOMINAL-TOL, NOMINAL+TOL]
LOCK_N, 3, consecutive good periods required to assert lock
CNT_W, 11, counter/period width; must hold NOMINAL+TOL+1

Ports:
clk  in  1  system clock (1 kHz in the flood design)
rst  in  1  synchronous reset, active-high
enable  in  1  monitor enable; low forces IDLE
tick_in  in  1  tick strobe from divider (nominally a 1-cycle pulse)
period  out  CNT_W  last measured period, held between updates
period_valid  out  1  1-cycle strobe: period updated
early  out  1  1-cycle strobe: period < NOMINAL-TOL
late  out  1  1-cycle strobe: period > NOMINAL+TOL, or timeout
missing  out  1  level: timeout occurred since the last good period
lock  out  1  level: LOCK_N consecutive good periods seen

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; period=0; period_valid, early, late, missing and lock = 0; streak=0; elapsed=0; tick_prev=0.
- Edge detect: an edge cycle is one where tick_in=1 and tick_prev=0. tick_prev is a register of tick_in. A tick held high counts once. A tick_in already high when reset releases counts as an edge on the first post-reset cycle.
- Period definition: edges detected at cycles t0 and t1 give period = t1-t0. A 1-cycle pulse every 1000 cycles measures 1000.
- All outputs are registered. Strobes appear the cycle after the deciding cycle and are high for exactly 1 cycle.
- IDLE:
  - elapsed held at 0.
  - On an edge (enable=1): go to MEASURE and restart elapsed. No period is reported.
- MEASURE: elapsed counts cycles since the last edge. On an edge, evaluate p = elapsed count:
  - p < NOMINAL-TOL: period=p, period_valid, early; streak=0; lock=0; restart elapsed.
  - NOMINAL-TOL ≤ p ≤ NOMINAL+TOL: period=p, period_valid; streak++ (saturate at LOCK_N); lock=1 when streak reaches LOCK_N; missing=0; restart elapsed.
  - p = NOMINAL+TOL+1: period=p, period_valid, late; streak=0; lock=0; restart elapsed; stay in MEASURE.
- Timeout: in MEASURE, when elapsed reaches NOMINAL+TOL+1 with no edge in that cycle:
  - late strobe (period_valid stays 0, period unchanged);
  - missing=1; lock=0; streak=0; go to IDLE.
  - elapsed never exceeds NOMINAL+TOL+1, so there is no counter wrap.
- enable=0:
  - forces IDLE; clears streak, lock, missing and the strobes;
  - period is held;
  - edges are ignored, but tick_prev still tracks tick_in.
- Priority: rst > enable=0 > edge > timeout.
- Reset mid-period discards the measurement in progress.

Test Plan:
- 1-cycle ticks every 1000 cycles, starting after reset → period_valid with period=1000 on each edge after the first; lock rises the cycle after the 3rd measured period; early and late never assert.
- Locked, then a gap of 900 → period=900, early=1 for 1 cycle, lock=0. The next three gaps of 1000 re-lock.
- Gaps of 998 and 1002 → good (period=998, period=1002), no early/late. A gap of 1003 → period=1003, late=1 for 1 cycle, lock=0, state remains MEASURE.
- Locked, then tick stops → late strobe exactly 1003 cycles after the last edge (+1 registered cycle), missing=1, lock=0, no period_valid. The next edge reports nothing. The following gap of 1000 clears missing.
- tick_in held high for 5 cycles each period, period 1000 → exactly one edge per period, period=1000, lock after 3 periods.
- Locked; assert rst mid-period for 1 cycle → all outputs 0 next cycle. Deassert enable for 200 cycles → lock=0, missing=0, period retains 1000, no strobes.
